// File: rtl/ps2_move_decoder_pkg.sv
// Shared constants for the PS/2 move decoder: move codes, scan set 2
// key codes, receiver states and the key-to-move mapping function.
package ps2_move_decoder_pkg;

    typedef enum logic [2:0] {
        MOVE_NONE  = 3'd0,
        MOVE_UP    = 3'd1,
        MOVE_DOWN  = 3'd2,
        MOVE_LEFT  = 3'd3,
        MOVE_RIGHT = 3'd4,
        MOVE_PLAY  = 3'd5,
        MOVE_RESET = 3'd6
    } move_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Arrow keys only count with the E0 prefix; letter keys only without.
    function automatic move_t map_key(input logic ext, input logic [7:0] code);
        move_t m;
        m = MOVE_NONE;
        if (ext) begin
            case (code)
                SC_UP:    m = MOVE_UP;
                SC_DOWN:  m = MOVE_DOWN;
                SC_LEFT:  m = MOVE_LEFT;
                SC_RIGHT: m = MOVE_RIGHT;
                default:  m = MOVE_NONE;
            endcase
        end else begin
            case (code)
                SC_W:     m = MOVE_UP;
                SC_S:     m = MOVE_DOWN;
                SC_A:     m = MOVE_LEFT;
                SC_D:     m = MOVE_RIGHT;
                SC_SPACE: m = MOVE_PLAY;
                SC_R:     m = MOVE_RESET;
                default:  m = MOVE_NONE;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_move_decoder_if.sv
// Bundle of the PS/2 line inputs and the move/frame_err outputs.
// slave: decoder side (reads PS/2 lines, drives move/frame_err).
// master: keyboard/consumer side (drives lines, reads results).
interface ps2_move_decoder_if;
    import ps2_move_decoder_pkg::*;

    logic  ps2_clk;
    logic  ps2_data;
    move_t move;
    logic  frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  move,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output move,
        output frame_err
    );

endinterface

// File: rtl/ps2_move_decoder_rx.sv
// PS/2 frame receiver: 2-FF synchronisers, clock glitch filter,
// start/data/parity/stop FSM and partial-frame timeout.
// Ports: clk, rst_n (sync, active-low), ps2_clk/ps2_data (raw async),
//        scan_code/byte_valid (good frame), frame_err (one-cycle pulse).
module ps2_move_decoder_rx
    import ps2_move_decoder_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_s;
    logic       dat_s;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // The filtered level follows the synchronised clock only after
    // FILTER_LEN consecutive differing samples; any agreeing sample
    // restarts the count, so short glitches never flip it.
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          flip;
    logic          strobe;

    assign flip   = (clk_s != filt) && (fcnt == FW'(FILTER_LEN - 1));
    assign strobe = flip && !clk_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= 1'b1;
            fcnt <= '0;
        end else if (clk_s == filt) begin
            fcnt <= '0;
        end else if (flip) begin
            filt <= clk_s;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

    rx_state_t     state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic          perr, perr_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          valid_n;
    logic          err_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            perr       <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            perr       <= perr_n;
            tcnt       <= tcnt_n;
            byte_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        perr_n   = perr;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        tcnt_n   = (state == RX_IDLE || strobe) ? '0 : tcnt + TW'(1);

        case (state)
            RX_IDLE: begin
                if (strobe) begin
                    if (!dat_s) begin
                        state_n  = RX_DATA;
                        bitcnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (strobe) begin
                    shreg_n  = {dat_s, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (strobe) begin
                    perr_n  = ~(^{shreg, dat_s});
                    state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (strobe) begin
                    state_n = RX_IDLE;
                    if (dat_s && !perr) begin
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase

        // A strobe in the same cycle keeps the frame alive.
        if (state != RX_IDLE && !strobe &&
            tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state_n = RX_IDLE;
            err_n   = 1'b1;
            tcnt_n  = '0;
        end
    end

    assign scan_code = shreg;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to game move command converter: E0/F0 prefix tracking,
// key mapping and auto-repeat suppression on top of the frame receiver.
// Ports: clk, rst_n (sync, active-low), bus (slave: ps2_clk, ps2_data in;
//        move, frame_err out, both registered one-cycle pulses).
module ps2_move_decoder
    import ps2_move_decoder_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input logic               clk,
    input logic               rst_n,
    ps2_move_decoder_if.slave bus
);

    logic [7:0] scan_code;
    logic       byte_valid;
    logic       rx_err;

    ps2_move_decoder_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .scan_code (scan_code),
        .byte_valid(byte_valid),
        .frame_err (rx_err)
    );

    logic       ext, ext_n;
    logic       brk, brk_n;
    logic [8:0] held, held_n;
    logic [8:0] key;
    move_t      move_q, move_n;
    logic       err_q, err_n;

    assign key = {ext, scan_code};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext    <= 1'b0;
            brk    <= 1'b0;
            held   <= '0;
            move_q <= MOVE_NONE;
            err_q  <= 1'b0;
        end else begin
            ext    <= ext_n;
            brk    <= brk_n;
            held   <= held_n;
            move_q <= move_n;
            err_q  <= err_n;
        end
    end

    // held remembers the last make so typematic repeats stay silent
    // until the matching break arrives or a different key is made.
    always_comb begin
        ext_n  = ext;
        brk_n  = brk;
        held_n = held;
        move_n = MOVE_NONE;
        err_n  = rx_err;

        if (rx_err) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end else if (byte_valid) begin
            unique case (1'b1)
                (scan_code == SC_EXT): ext_n = 1'b1;
                (scan_code == SC_BRK): brk_n = 1'b1;
                default: begin
                    ext_n = 1'b0;
                    brk_n = 1'b0;
                    if (brk) begin
                        if (key == held) begin
                            held_n = '0;
                        end
                    end else if (key != held) begin
                        held_n = key;
                        move_n = map_key(ext, scan_code);
                    end
                end
            endcase
        end
    end

    assign bus.move      = move_q;
    assign bus.frame_err = err_q;

endmodule
